// File: rtl/snake_engine_if.sv
`default_nettype none
// ============================================================================
// Module      : snake_engine_if
// Description : Control inputs and display-facing game state of snake_engine.
//               The master drives move/direction requests; the slave (engine)
//               returns the packed snake, food, length, score and game-over.
// Revision    : 1.0 - initial release
// ============================================================================
interface snake_engine_if #(
  parameter int XB = 6,
  parameter int YB = 5,
  parameter int N  = 16,
  parameter int LB = 5
);
  logic              Tick;
  logic [1:0]        DirIn;
  logic              DirValid;
  logic [0:N*YB-1]   packSnakeY;
  logic [0:N*XB-1]   packSnakeX;
  logic [YB-1:0]     foodY;
  logic [XB-1:0]     foodX;
  logic [LB-1:0]     Length;
  logic [7:0]        Score;
  logic              GameOver;

  modport master (
    output Tick, DirIn, DirValid,
    input  packSnakeY, packSnakeX, foodY, foodX, Length, Score, GameOver
  );

  modport slave (
    input  Tick, DirIn, DirValid,
    output packSnakeY, packSnakeX, foodY, foodX, Length, Score, GameOver
  );
endinterface
`default_nettype wire

// File: rtl/snake_engine.sv
`default_nettype none
// ============================================================================
// Module      : snake_engine
// Description : Snake game-state core: body, direction, food placement,
//               growth, score and collision detection, advanced one grid cell
//               per movement strobe. Feeds the display stage.
// Revision    : 1.0 - initial release
// ============================================================================
module snake_engine #(
  parameter int GRID_WIDTH       = 40,
  parameter int GRID_HEIGHT      = 30,
  parameter int NUM_SNAKE_PIECES = 16,
  parameter int START_LEN        = 3,
  parameter int XB               = $clog2(GRID_WIDTH),
  parameter int YB               = $clog2(GRID_HEIGHT)
) (
  input  logic          Clock,
  input  logic          Reset_n,
  snake_engine_if.slave bus
);

  localparam int N  = NUM_SNAKE_PIECES;
  localparam int LB = $clog2(NUM_SNAKE_PIECES) + 1;
  localparam int CX = GRID_WIDTH / 2;
  localparam int CY = GRID_HEIGHT / 2;

  typedef enum logic [1:0] {
    ST_WAIT = 2'd0,
    ST_FOOD = 2'd1,
    ST_OVER = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [XB-1:0] px_q [N];
  logic [XB-1:0] px_d [N];
  logic [YB-1:0] py_q [N];
  logic [YB-1:0] py_d [N];
  logic [LB-1:0] len_q, len_d;
  logic [1:0]    dir_q, dir_d;
  logic [1:0]    pend_q, pend_d;
  logic [XB-1:0] food_x_q, food_x_d;
  logic [YB-1:0] food_y_q, food_y_d;
  logic [7:0]    score_q, score_d;
  logic          over_q, over_d;
  logic          hold_q, hold_d;
  logic [15:0]   lfsr_q, lfsr_d;

  logic [XB-1:0] nx, cand_x;
  logic [YB-1:0] ny, cand_y;
  logic          eat, wall, hit, grow, cand_ok, dir_ok, move;
  int            hit_lim;
  logic [0:N*YB-1] pack_y;
  logic [0:N*XB-1] pack_x;

  // Next-state logic: movement, collision, growth, food search and direction latching
  always_comb begin
    state_d  = state_q;
    px_d     = px_q;
    py_d     = py_q;
    len_d    = len_q;
    dir_d    = dir_q;
    pend_d   = pend_q;
    food_x_d = food_x_q;
    food_y_d = food_y_q;
    score_d  = score_q;
    over_d   = over_q;
    hold_d   = hold_q;
    lfsr_d   = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};

    // Head one cell along the pending direction; the head is always interior,
    // so the step can reach a wall but never wrap.
    nx = px_q[0];
    ny = py_q[0];
    case (pend_q)
      2'b00:   ny = py_q[0] - YB'(1);
      2'b01:   nx = px_q[0] + XB'(1);
      2'b10:   ny = py_q[0] + YB'(1);
      default: nx = px_q[0] - XB'(1);
    endcase

    eat  = (nx == food_x_q) && (ny == food_y_q);
    wall = (nx == '0) || (nx == XB'(GRID_WIDTH - 1)) ||
           (ny == '0) || (ny == YB'(GRID_HEIGHT - 1));
    grow = eat && (int'(len_q) < N);

    // The tail vacates its cell during the move unless the snake is eating.
    hit_lim = eat ? int'(len_q) : int'(len_q) - 1;
    hit     = 1'b0;
    for (int i = 0; i < N; i++) begin
      if ((i < hit_lim) && (px_q[i] == nx) && (py_q[i] == ny)) hit = 1'b1;
    end

    cand_x  = lfsr_q[XB-1:0];
    cand_y  = lfsr_q[8 +: YB];
    cand_ok = (int'(cand_x) >= 1) && (int'(cand_x) <= GRID_WIDTH - 2) &&
              (int'(cand_y) >= 1) && (int'(cand_y) <= GRID_HEIGHT - 2);
    for (int i = 0; i < N; i++) begin
      if ((i < int'(len_q)) && (px_q[i] == cand_x) && (py_q[i] == cand_y)) cand_ok = 1'b0;
    end

    dir_ok = bus.DirValid && (bus.DirIn != (dir_q ^ 2'b10));
    move   = bus.Tick || hold_q;

    case (state_q)
      ST_WAIT: begin
        if (dir_ok) pend_d = bus.DirIn;
        if (move) begin
          hold_d = 1'b0;
          if (wall || hit) begin
            over_d  = 1'b1;
            state_d = ST_OVER;
          end else begin
            // Shift body; on growth the old last piece is duplicated into slot len.
            for (int i = 1; i < N; i++) begin
              if ((i < int'(len_q)) || (grow && (i == int'(len_q)))) begin
                px_d[i] = px_q[i-1];
                py_d[i] = py_q[i-1];
              end
            end
            px_d[0] = nx;
            py_d[0] = ny;
            dir_d   = pend_q;
            if (eat) begin
              score_d = score_q + 8'd1;
              state_d = ST_FOOD;
              if (grow) len_d = len_q + LB'(1);
            end
          end
        end
      end
      ST_FOOD: begin
        if (dir_ok) pend_d = bus.DirIn;
        if (bus.Tick) hold_d = 1'b1;
        if (cand_ok) begin
          food_x_d = cand_x;
          food_y_d = cand_y;
          state_d  = ST_WAIT;
        end
      end
      default: begin
      end
    endcase
  end

  // State registers with synchronous active-low reset to the starting layout
  always_ff @(posedge Clock) begin
    if (!Reset_n) begin
      for (int i = 0; i < N; i++) begin
        px_q[i] <= (i < START_LEN) ? XB'(CX - i) : '0;
        py_q[i] <= (i < START_LEN) ? YB'(CY) : '0;
      end
      state_q  <= ST_WAIT;
      len_q    <= LB'(START_LEN);
      dir_q    <= 2'b01;
      pend_q   <= 2'b01;
      food_x_q <= XB'(CX + 4);
      food_y_q <= YB'(CY);
      score_q  <= 8'd0;
      over_q   <= 1'b0;
      hold_q   <= 1'b0;
      lfsr_q   <= 16'hACE1;
    end else begin
      px_q     <= px_d;
      py_q     <= py_d;
      state_q  <= state_d;
      len_q    <= len_d;
      dir_q    <= dir_d;
      pend_q   <= pend_d;
      food_x_q <= food_x_d;
      food_y_q <= food_y_d;
      score_q  <= score_d;
      over_q   <= over_d;
      hold_q   <= hold_d;
      lfsr_q   <= lfsr_d;
    end
  end

  // Pack pieces bitwise into ascending-range vectors: bit k of piece h at h*W+k
  always_comb begin
    pack_x = '0;
    pack_y = '0;
    for (int h = 0; h < N; h++) begin
      for (int k = 0; k < XB; k++) pack_x[h*XB + k] = px_q[h][k];
      for (int k = 0; k < YB; k++) pack_y[h*YB + k] = py_q[h][k];
    end
  end

  assign bus.packSnakeX = pack_x;
  assign bus.packSnakeY = pack_y;
  assign bus.foodX      = food_x_q;
  assign bus.foodY      = food_y_q;
  assign bus.Length     = len_q;
  assign bus.Score      = score_q;
  assign bus.GameOver   = over_q;

endmodule
`default_nettype wire

// File: tb/tb_snake_engine.sv
`default_nettype none
// ============================================================================
// Module      : tb_snake_engine
// Description : Self-checking bench for snake_engine: directed scenarios plus
//               randomized play compared every cycle against a queue-based
//               reference model of the game rules.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_snake_engine;

  localparam int GW = 40;
  localparam int GH = 30;
  localparam int N  = 16;
  localparam int XB = 6;
  localparam int YB = 5;
  localparam int LB = 5;
  localparam int M_WAIT = 0;
  localparam int M_FOOD = 1;
  localparam int M_OVER = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_vec = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  snake_engine_if #(.XB(XB), .YB(YB), .N(N), .LB(LB)) bus ();
  snake_engine_if #(.XB(XB), .YB(YB), .N(N), .LB(LB)) bus5 ();

  snake_engine #(.GRID_WIDTH(GW), .GRID_HEIGHT(GH), .NUM_SNAKE_PIECES(N), .START_LEN(3))
    dut (.Clock(clk), .Reset_n(rst_n), .bus(bus));
  snake_engine #(.GRID_WIDTH(GW), .GRID_HEIGHT(GH), .NUM_SNAKE_PIECES(N), .START_LEN(5))
    dut5 (.Clock(clk), .Reset_n(rst_n), .bus(bus5));

  // ---------------- reference model ----------------
  typedef struct {int x; int y;} pt_t;
  pt_t sn[$];
  int  m_dir, m_pend, m_fx, m_fy, m_score, m_over, m_mode, m_hold, m_lfsr;

  function automatic void m_reset();
    pt_t p;
    sn.delete();
    for (int i = 0; i < 3; i++) begin
      p.x = GW/2 - i; p.y = GH/2; sn.push_back(p);
    end
    m_dir = 1; m_pend = 1; m_fx = GW/2 + 4; m_fy = GH/2;
    m_score = 0; m_over = 0; m_mode = M_WAIT; m_hold = 0; m_lfsr = 'hACE1;
  endfunction

  function automatic int lfsr_next(int v);
    int fb;
    fb = ((v >> 15) ^ (v >> 13) ^ (v >> 12) ^ (v >> 10)) & 1;
    return ((v << 1) | fb) & 'hFFFF;
  endfunction

  function automatic void m_step(bit rn, bit tk, bit dv, int d);
    pt_t nh;
    int  odir, omode, lim, cx, cy;
    bit  eat, coll, grow, ok;
    if (!rn) begin
      m_reset();
      return;
    end
    odir = m_dir; omode = m_mode;
    if (m_mode == M_WAIT && (tk || m_hold)) begin
      m_hold = 0;
      nh = sn[0];
      case (m_pend)
        0: nh.y--; 1: nh.x++; 2: nh.y++; default: nh.x--;
      endcase
      eat  = (nh.x == m_fx) && (nh.y == m_fy);
      coll = (nh.x == 0) || (nh.x == GW-1) || (nh.y == 0) || (nh.y == GH-1);
      lim  = eat ? sn.size() : sn.size() - 1;
      for (int i = 0; i < lim; i++) if (sn[i].x == nh.x && sn[i].y == nh.y) coll = 1;
      if (coll) begin
        m_over = 1; m_mode = M_OVER;
      end else begin
        grow = eat && (sn.size() < N);
        sn.push_front(nh);
        if (!grow) void'(sn.pop_back());
        m_dir = m_pend;
        if (eat) begin m_score = (m_score + 1) % 256; m_mode = M_FOOD; end
      end
    end else if (m_mode == M_FOOD) begin
      if (tk) m_hold = 1;
      cx = m_lfsr % (1 << XB);
      cy = (m_lfsr >> 8) % (1 << YB);
      ok = (cx >= 1) && (cx <= GW-2) && (cy >= 1) && (cy <= GH-2);
      foreach (sn[i]) if (sn[i].x == cx && sn[i].y == cy) ok = 0;
      if (ok) begin m_fx = cx; m_fy = cy; m_mode = M_WAIT; end
    end
    if (omode != M_OVER && dv && d != (odir ^ 2)) m_pend = d;
    m_lfsr = lfsr_next(m_lfsr);
  endfunction

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int hx(int h);
    logic [31:0] r = '0;
    for (int k = 0; k < XB; k++) r[k] = bus.packSnakeX[h*XB + k];
    return int'(r);
  endfunction
  function automatic int hy(int h);
    logic [31:0] r = '0;
    for (int k = 0; k < YB; k++) r[k] = bus.packSnakeY[h*YB + k];
    return int'(r);
  endfunction
  function automatic int h5x(int h);
    logic [31:0] r = '0;
    for (int k = 0; k < XB; k++) r[k] = bus5.packSnakeX[h*XB + k];
    return int'(r);
  endfunction
  function automatic int h5y(int h);
    logic [31:0] r = '0;
    for (int k = 0; k < YB; k++) r[k] = bus5.packSnakeY[h*YB + k];
    return int'(r);
  endfunction

  task automatic compare_all();
    logic [127:0] gx, gy, ex, ey;
    int vx, vy;
    gx = '0; gy = '0; ex = '0; ey = '0;
    for (int i = 0; i < N*XB; i++) gx[i] = bus.packSnakeX[i];
    for (int i = 0; i < N*YB; i++) gy[i] = bus.packSnakeY[i];
    for (int h = 0; h < N; h++) begin
      vx = (h < sn.size()) ? sn[h].x : 0;
      vy = (h < sn.size()) ? sn[h].y : 0;
      for (int k = 0; k < XB; k++) ex[h*XB + k] = vx[k];
      for (int k = 0; k < YB; k++) ey[h*YB + k] = vy[k];
    end
    check("packX", gx, ex);
    check("packY", gy, ey);
    check("foodX", bus.foodX, m_fx);
    check("foodY", bus.foodY, m_fy);
    check("Length", bus.Length, sn.size());
    check("Score", bus.Score, m_score);
    check("GameOver", bus.GameOver, m_over);
  endtask

  task automatic cyc(input bit rn, input bit tk, input bit dv, input logic [1:0] d);
    rst_n = rn; bus.Tick = tk; bus.DirValid = dv; bus.DirIn = d;
    @(posedge clk);
    m_step(rn, tk, dv, int'(d));
    #1;
    compare_all();
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_h0"}, {hx(0), hy(0)}, {32'd20, 32'd15});
    check({tag, "_h1"}, {hx(1), hy(1)}, {32'd19, 32'd15});
    check({tag, "_h2"}, {hx(2), hy(2)}, {32'd18, 32'd15});
    for (int h = 3; h < N; h++) check({tag, "_slot"}, {hx(h), hy(h)}, 64'd0);
    check({tag, "_food"}, {bus.foodX, bus.foodY}, {6'd24, 5'd15});
    check({tag, "_len"}, bus.Length, 3);
    check({tag, "_score"}, bus.Score, 0);
    check({tag, "_over"}, bus.GameOver, 0);
  endtask

  function automatic logic [1:0] toward_food();
    if (m_fx > sn[0].x) return 2'b01;
    if (m_fx < sn[0].x) return 2'b11;
    if (m_fy > sn[0].y) return 2'b10;
    return 2'b00;
  endfunction

  // ---------------- stimulus ----------------
  initial begin
    bit done;
    int fx, fy;
    bit ok;
    bus.Tick = 0; bus.DirValid = 0; bus.DirIn = 0;
    bus5.Tick = 0; bus5.DirValid = 0; bus5.DirIn = 0;

    // Reset state
    cyc(0, 0, 0, 0);
    cyc(1, 0, 0, 0);
    check_reset_state("reset");

    // Four moves right, the fourth eats
    for (int i = 0; i < 4; i++) cyc(1, 1, 0, 0);
    check("eat_h0", {hx(0), hy(0)}, {32'd24, 32'd15});
    check("eat_h1", {hx(1), hy(1)}, {32'd23, 32'd15});
    check("eat_h2", {hx(2), hy(2)}, {32'd22, 32'd15});
    check("eat_h3", {hx(3), hy(3)}, {32'd21, 32'd15});
    check("eat_len", bus.Length, 4);
    check("eat_score", bus.Score, 1);
    done = 0;
    for (int i = 0; i < 300 && !done; i++) begin
      cyc(1, 0, 0, 0);
      if (bus.foodX != 6'd24 || bus.foodY != 5'd15) done = 1;
    end
    check("food_moved", done, 1);
    fx = int'(bus.foodX); fy = int'(bus.foodY);
    ok = (fx >= 1) && (fx <= GW-2) && (fy >= 1) && (fy <= GH-2);
    for (int h = 0; h < 4; h++) if (hx(h) == fx && hy(h) == fy) ok = 0;
    check("food_legal", ok, 1);

    // Reverse request ignored, then turn up
    cyc(0, 0, 0, 0);
    cyc(1, 0, 1, 2'b11);
    cyc(1, 1, 0, 0);
    check("rev_head", {hx(0), hy(0)}, {32'd21, 32'd15});
    cyc(1, 0, 1, 2'b00);
    cyc(1, 1, 0, 0);
    check("up_head", {hx(0), hy(0)}, {32'd21, 32'd14});

    // Run into the top wall
    cyc(0, 0, 0, 0);
    cyc(1, 0, 1, 2'b00);
    for (int i = 0; i < 14; i++) cyc(1, 1, 0, 0);
    check("wall_pre_head", {hx(0), hy(0)}, {32'd20, 32'd1});
    check("wall_pre_over", bus.GameOver, 0);
    cyc(1, 1, 0, 0);
    check("wall_over", bus.GameOver, 1);
    check("wall_head", {hx(0), hy(0)}, {32'd20, 32'd1});
    for (int i = 0; i < 3; i++) cyc(1, 1, 1, 2'b01);
    check("frozen_head", {hx(0), hy(0)}, {32'd20, 32'd1});
    check("frozen_len", bus.Length, 3);

    // Self collision with a five-piece snake
    cyc(0, 0, 0, 0);
    bus5.DirValid = 1; bus5.DirIn = 2'b00; cyc(1, 0, 0, 0); bus5.DirValid = 0;
    bus5.Tick = 1; cyc(1, 0, 0, 0); bus5.Tick = 0;
    bus5.DirValid = 1; bus5.DirIn = 2'b11; cyc(1, 0, 0, 0); bus5.DirValid = 0;
    bus5.Tick = 1; cyc(1, 0, 0, 0); bus5.Tick = 0;
    check("s5_head", {h5x(0), h5y(0)}, {32'd19, 32'd14});
    check("s5_pre_over", bus5.GameOver, 0);
    bus5.DirValid = 1; bus5.DirIn = 2'b10; cyc(1, 0, 0, 0); bus5.DirValid = 0;
    bus5.Tick = 1; cyc(1, 0, 0, 0); bus5.Tick = 0;
    check("s5_over", bus5.GameOver, 1);
    check("s5_len", bus5.Length, 5);

    // Reset while searching for food
    cyc(0, 0, 0, 0);
    for (int i = 0; i < 4; i++) cyc(1, 1, 0, 0);
    check("food_mode", m_mode, M_FOOD);
    cyc(0, 0, 0, 0);
    check_reset_state("rst_food");

    // Tick during the food search is held and executed afterwards
    cyc(1, 0, 0, 0);
    for (int i = 0; i < 4; i++) cyc(1, 1, 0, 0);
    cyc(1, 1, 0, 0);
    done = 0;
    for (int i = 0; i < 300 && !done; i++) begin
      cyc(1, 0, 0, 0);
      if (hx(0) == 25) done = 1;
    end
    check("held_tick", done, 1);

    // Randomized play, steered toward food part of the time
    cyc(0, 0, 0, 0);
    for (int n = 0; n < 3000; n++) begin
      bit rn, tk, dv;
      logic [1:0] d;
      rn = ($urandom_range(0, 299) != 0);
      if (m_over != 0 && $urandom_range(0, 7) == 0) rn = 0;
      tk = ($urandom_range(0, 2) == 0);
      dv = ($urandom_range(0, 2) == 0);
      d  = ($urandom_range(0, 1) == 0) ? toward_food() : 2'($urandom_range(0, 3));
      cyc(rn, tk, dv, d);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
